tlc_phase_scheduler: RTL and testbench

Demand-driven phase scheduler for the four-approach junction: main through (light_M1, light_M2), main turn (light_MT) and side road (light_S).
- Rests in MAIN green.
- Latches turn/side detector requests and arbitrates them round-robin.
- Sequences each change through yellow and all-red clearance, timed in tick units.
- Replaces the fixed-cycle sequencer; drives the lamp drivers directly.

---
 rtl/tlc_pkg.sv | 19 +
 rtl/tlc_phase_timer.sv | 29 ++
 rtl/tlc_phase_scheduler.sv | 109 ++++++++++
 tb/tb_tlc_phase_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared lamp codes, phase/state encodings and per-phase green masks
// Used by tlc_phase_scheduler and tlc_phase_timer.
package tlc_pkg;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    typedef logic [1:0] phase_t;
    localparam phase_t PH_MAIN = 2'd0;
    localparam phase_t PH_TURN = 2'd1;
    localparam phase_t PH_SIDE = 2'd2;
    typedef logic [1:0] state_t;
    localparam state_t ST_GREEN  = 2'd0;
    localparam state_t ST_YELLOW = 2'd1;
    localparam state_t ST_ALLRED = 2'd2;
    // Approaches shown green in a phase, bit order {S, MT, M2, M1}.
    function automatic logic [3:0] green_mask(input phase_t ph);
        return ph == PH_MAIN ? 4'b0011 : ph == PH_TURN ? 4'b0101 : ph == PH_SIDE ? 4'b1000 : 4'b0000;
    endfunction
endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: tick-gated state timer with clear, duration input and saturate mode
// Ports: clk, reset (async active-low), tick (advance strobe), clr (restart at 0),
//        sat (hold at last count instead of advancing), dur (duration in ticks),
//        done (count has reached dur-1).
module tlc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clr,
    input  logic             sat,
    input  logic [CNT_W:0]   dur,
    output logic             done
);
    localparam logic [CNT_W-1:0] ONE  = 1;
    localparam logic [CNT_W:0]   ONEW = 1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   last;
    always_comb begin
        last    = dur - ONEW;
        done    = {1'b0, count_q} == last;
        count_d = clr ? '0 : (tick && !(sat && done)) ? count_q + ONE : count_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: demand-driven MAIN/TURN/SIDE phase scheduler with yellow and all-red clearance
// Ports: clk, reset (async active-low), tick (timebase strobe), req_turn/req_side (latched
//        detector requests), light_M1/M2/MT/S (lamp codes), phase (current phase), pend ({side, turn}).
// Optional: define TLC_PREEMPT_EN to add input preempt, which cuts TURN/SIDE green short and holds MAIN.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int T_MAIN_MIN = 7,
    parameter int T_TURN     = 5,
    parameter int T_SIDE     = 3,
    parameter int T_YEL      = 2,
    parameter int T_AR       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_turn,
    input  logic       req_side,
`ifdef TLC_PREEMPT_EN
    input  logic       preempt,
`endif
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [1:0] phase,
    output logic [1:0] pend
);
    localparam logic [CNT_W:0] D_MAIN = (CNT_W+1)'(T_MAIN_MIN);
    localparam logic [CNT_W:0] D_TURN = (CNT_W+1)'(T_TURN);
    localparam logic [CNT_W:0] D_SIDE = (CNT_W+1)'(T_SIDE);
    localparam logic [CNT_W:0] D_YEL  = (CNT_W+1)'(T_YEL);
    localparam logic [CNT_W:0] D_AR   = (CNT_W+1)'(T_AR);

    state_t       state_q, state_d;
    phase_t       cur_q, cur_d, nxt_q, nxt_d;
    logic [1:0]   pend_q, pend_d, pend_set, pend_clr;
    logic         rr_q, rr_d;
    logic [CNT_W:0] dur;
    logic         sat, done, leave_green, adv, pick_turn;
    logic [3:0]   gc, gn;
    logic [2:0]   lamp [4];

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .clr   (adv),
        .sat   (sat),
        .dur   (dur),
        .done  (done)
    );

    always_comb begin
        // Requests seen this cycle already count toward the MAIN-exit decision.
        pend_set  = pend_q | {req_side, req_turn};
        dur       = state_q == ST_GREEN ? (cur_q == PH_MAIN ? D_MAIN : cur_q == PH_TURN ? D_TURN : D_SIDE)
                  : state_q == ST_YELLOW ? D_YEL : D_AR;
        sat       = state_q == ST_GREEN && cur_q == PH_MAIN;
`ifdef TLC_PREEMPT_EN
        leave_green = cur_q == PH_MAIN ? (done && pend_set != 2'b00 && !preempt) : (done || preempt);
`else
        leave_green = cur_q == PH_MAIN ? (done && pend_set != 2'b00) : done;
`endif
        adv       = tick && (state_q == ST_GREEN ? leave_green : done);
        pick_turn = pend_set[0] && (!pend_set[1] || !rr_q);
        state_d   = !adv ? state_q : state_q == ST_GREEN ? ST_YELLOW : state_q == ST_YELLOW ? ST_ALLRED : ST_GREEN;
        cur_d     = adv && state_q == ST_ALLRED ? nxt_q : cur_q;
        nxt_d     = adv && state_q == ST_GREEN ? (cur_q != PH_MAIN ? PH_MAIN : pick_turn ? PH_TURN : PH_SIDE) : nxt_q;
        // rr points at whichever request was not just served from MAIN.
        rr_d      = adv && sat ? pick_turn : rr_q;
        pend_clr  = adv && state_q == ST_ALLRED ? {nxt_q == PH_SIDE, nxt_q == PH_TURN} : 2'b00;
        pend_d    = (pend_q & ~pend_clr) | {req_side, req_turn};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_GREEN;
            cur_q   <= PH_MAIN;
            nxt_q   <= PH_MAIN;
            pend_q  <= 2'b00;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
        end
    end

    // An approach green in both phases stays green through the change.
    always_comb begin
        gc = green_mask(cur_q);
        gn = green_mask(nxt_q);
        for (int i = 0; i < 4; i++) begin
            lamp[i] = (gc[i] && (state_q == ST_GREEN || gn[i])) ? LAMP_GRN
                    : (gc[i] && state_q == ST_YELLOW) ? LAMP_YEL : LAMP_RED;
        end
    end

    assign light_M1 = lamp[0];
    assign light_M2 = lamp[1];
    assign light_MT = lamp[2];
    assign light_S  = lamp[3];
    assign phase    = cur_q;
    assign pend     = pend_q;
endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb_tlc_phase_scheduler: scoreboard bench for tlc_phase_scheduler
module tb_tlc_phase_scheduler;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic req_turn = 1'b0;
    logic req_side = 1'b0;
`ifdef TLC_PREEMPT_EN
    logic preempt = 1'b0;
`endif
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [1:0] phase, pend;
    logic [15:0] obs, exp_v;
    logic [15:0] sb[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlc_phase_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req_turn (req_turn),
        .req_side (req_side),
`ifdef TLC_PREEMPT_EN
        .preempt  (preempt),
`endif
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S),
        .phase    (phase),
        .pend     (pend)
    );

    assign obs = {phase, pend, light_M1, light_M2, light_MT, light_S};

    task automatic push(input int n, input logic [1:0] ph, input logic [1:0] pd,
                        input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt, input logic [2:0] s);
        for (int k = 0; k < n; k++) sb.push_back({ph, pd, m1, m2, mt, s});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick = 1'b0;
        req_turn = 1'b0;
        req_side = 1'b0;
`ifdef TLC_PREEMPT_EN
        preempt = 1'b0;
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        push(50, 0, 2'b00, G, G, R, R);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== {2'd0, 2'b00, G, G, R, R}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs, {2'd0, 2'b00, G, G, R, R});
        end
        reset = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            tick = 1'b1;
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL idle_main j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_side();
        do_reset();
        push(1, 0, 2'b00, G, G, R, R);
        push(5, 0, 2'b10, G, G, R, R);
        push(2, 0, 2'b10, Y, Y, R, R);
        push(1, 0, 2'b10, R, R, R, R);
        push(3, 2, 2'b00, R, R, R, G);
        push(2, 2, 2'b00, R, R, R, Y);
        push(1, 2, 2'b00, R, R, R, R);
        push(5, 0, 2'b00, G, G, R, R);
        for (int j = 1; j <= 20; j++) begin
            tick = 1'b1;
            req_side = (j == 2);
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL side_cycle j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        push(6, 0, 2'b11, G, G, R, R);
        push(2, 0, 2'b11, G, Y, R, R);
        push(1, 0, 2'b11, G, R, R, R);
        push(5, 1, 2'b10, G, R, G, R);
        push(2, 1, 2'b10, G, R, Y, R);
        push(1, 1, 2'b10, G, R, R, R);
        push(7, 0, 2'b10, G, G, R, R);
        push(2, 0, 2'b10, Y, Y, R, R);
        push(1, 0, 2'b10, R, R, R, R);
        push(3, 2, 2'b00, R, R, R, G);
        push(2, 2, 2'b00, R, R, R, Y);
        push(1, 2, 2'b00, R, R, R, R);
        push(1, 0, 2'b00, G, G, R, R);
        for (int j = 1; j <= 34; j++) begin
            tick = 1'b1;
            req_turn = (j == 1);
            req_side = (j == 1);
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL arbitration j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_tick_gating();
        do_reset();
        push(27, 0, 2'b01, G, G, R, R);
        push(8, 0, 2'b01, G, Y, R, R);
        push(4, 0, 2'b01, G, R, R, R);
        push(20, 1, 2'b00, G, R, G, R);
        push(8, 1, 2'b00, G, R, Y, R);
        push(4, 1, 2'b00, G, R, R, R);
        push(4, 0, 2'b00, G, G, R, R);
        for (int j = 1; j <= 75; j++) begin
            tick = (j % 4 == 0);
            req_turn = (j == 1);
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tick_gating j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(6, 0, 2'b10, G, G, R, R);
        push(2, 0, 2'b10, Y, Y, R, R);
        push(1, 0, 2'b10, R, R, R, R);
        push(3, 2, 2'b10, R, R, R, G);
        push(2, 2, 2'b10, R, R, R, Y);
        push(1, 2, 2'b10, R, R, R, R);
        push(7, 0, 2'b10, G, G, R, R);
        push(2, 0, 2'b10, Y, Y, R, R);
        push(1, 0, 2'b10, R, R, R, R);
        push(1, 2, 2'b10, R, R, R, G);
        for (int j = 1; j <= 26; j++) begin
            tick = 1'b1;
            req_side = 1'b1;
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL held_side j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
        req_side = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(6, 0, 2'b10, G, G, R, R);
        push(1, 0, 2'b10, Y, Y, R, R);
        push(1, 0, 2'b11, Y, Y, R, R);
        for (int j = 1; j <= 8; j++) begin
            tick = 1'b1;
            req_side = (j == 1);
            req_turn = (j == 8);
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pre_reset j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
        req_turn = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== {2'd0, 2'b00, G, G, R, R}) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", obs, {2'd0, 2'b00, G, G, R, R});
        end
        @(negedge clk);
        checks++;
        if (obs !== {2'd0, 2'b00, G, G, R, R}) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, {2'd0, 2'b00, G, G, R, R});
        end
        reset = 1'b1;
        push(12, 0, 2'b00, G, G, R, R);
        for (int j = 1; j <= 12; j++) begin
            tick = 1'b1;
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

`ifdef TLC_PREEMPT_EN
    task automatic test_preempt();
        do_reset();
        push(6, 0, 2'b10, G, G, R, R);
        push(2, 0, 2'b10, Y, Y, R, R);
        push(1, 0, 2'b10, R, R, R, R);
        push(1, 2, 2'b00, R, R, R, G);
        push(1, 2, 2'b00, R, R, R, Y);
        push(1, 2, 2'b01, R, R, R, Y);
        push(1, 2, 2'b01, R, R, R, R);
        push(17, 0, 2'b01, G, G, R, R);
        push(2, 0, 2'b01, G, Y, R, R);
        push(1, 0, 2'b01, G, R, R, R);
        push(1, 1, 2'b00, G, R, G, R);
        for (int j = 1; j <= 34; j++) begin
            tick = 1'b1;
            req_side = (j == 1);
            req_turn = (j == 12);
            preempt = (j >= 11 && j <= 30);
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL preempt j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
        preempt = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_side();
        test_arbitration();
        test_tick_gating();
        test_back_to_back();
        test_mid_reset();
`ifdef TLC_PREEMPT_EN
        test_preempt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
